// File: rtl/if_fetch_buffer_pkg.sv
// Shared RV32I fetch-path definitions: the canonical NOP and the buffered fetch entry.
package RV32I_definitions;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam int FETCH_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_fifo2.sv
// Two-entry in-order FIFO of fetch entries; slot 0 is always the head.
module fetch_fifo2
  import RV32I_definitions::*;
(
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry_reg [FETCH_FIFO_DEPTH];
  logic [1:0]   count_reg;
  logic [1:0]   wr_idx;

  // The incoming word lands just behind whatever survives this cycle's pop.
  assign wr_idx = count_reg - {1'b0, pop};

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        entry_reg[0] <= entry_reg[1];
      end
      if (push) begin
        entry_reg[wr_idx[0]] <= din;
      end
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues IMEM reads, pairs returned words with their PC,
// buffers up to two entries for ID and squashes wrong-path fetches on redirect.
module if_fetch_buffer
  import RV32I_definitions::*;
#(
  parameter int          IMEM_ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_INSTR       = RV32I_definitions::NOP_INSTR
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [31:0]                PC_In,
  output logic                       PC_Stall,
  output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
  input  logic [31:0]                IMEM_Data,
  input  logic                       ID_Jump,
  input  logic                       EX_PC_Branch,
  input  logic                       ID_Stall,
  output logic                       ID_Valid,
  output logic [31:0]                ID_Instr,
  output logic [31:0]                ID_PC,
  output logic                       ID_Misaligned
);

  logic         flush;
  logic         pop;
  logic         push;
  logic         issue;
  logic         id_valid;
  logic [1:0]   count;
  logic [2:0]   occupancy;
  logic         req_valid_reg;
  logic [31:0]  req_pc_reg;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign flush    = ID_Jump | EX_PC_Branch;
  assign id_valid = Reset_n & (count != 2'd0);
  assign pop      = id_valid & ~ID_Stall;

  // Entries the buffer must hold after this edge if one more fetch were issued now.
  assign occupancy = {1'b0, count} - {2'b0, pop} + {2'b0, req_valid_reg};
  assign PC_Stall  = Reset_n & ~flush & (occupancy >= 3'd2);
  assign issue     = Reset_n & ~PC_Stall;

  assign IMEM_Addr = PC_In[IMEM_ADDR_WIDTH+1:2];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      req_valid_reg <= 1'b0;
      req_pc_reg    <= '0;
    end else begin
      req_valid_reg <= issue & ~flush;
      if (issue) begin
        req_pc_reg <= PC_In;
      end
    end
  end

  assign push = req_valid_reg & ~flush;

  assign push_entry = '{pc: req_pc_reg, instr: IMEM_Data, misaligned: |req_pc_reg[1:0]};

  fetch_fifo2 u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push),
    .pop     (pop & ~flush),
    .clear   (flush),
    .din     (push_entry),
    .head    (head),
    .count   (count)
  );

  assign ID_Valid      = id_valid;
  assign ID_Instr      = id_valid ? head.instr : NOP_INSTR;
  assign ID_PC         = id_valid ? head.pc : 32'd0;
  assign ID_Misaligned = id_valid & head.misaligned;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a simple PC register and synchronous IMEM
// whose word at address k is 0x1000_0000+k.
module tb_if_fetch_buffer;

  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc_reg;
  logic          pc_stall;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          id_jump;
  logic          ex_branch;
  logic          id_stall;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          id_misaligned;
  logic [31:0]   target;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  if_fetch_buffer #(.IMEM_ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .PC_In         (pc_reg),
    .PC_Stall      (pc_stall),
    .IMEM_Addr     (imem_addr),
    .IMEM_Data     (imem_data),
    .ID_Jump       (id_jump),
    .EX_PC_Branch  (ex_branch),
    .ID_Stall      (id_stall),
    .ID_Valid      (id_valid),
    .ID_Instr      (id_instr),
    .ID_PC         (id_pc),
    .ID_Misaligned (id_misaligned)
  );

  // PC register: its own stall wins over nothing here because the DUT drops stall on redirect.
  always @(posedge clk) begin
    if (!rst_n)                  pc_reg <= 32'd0;
    else if (id_jump | ex_branch) pc_reg <= target;
    else if (!pc_stall)          pc_reg <= pc_reg + 32'd4;
  end

  always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %08h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_jump = 1'b0; ex_branch = 1'b0; id_stall = 1'b0; target = 32'd0;
    next_cycle();
    next_cycle();
    #1;
    check("rst_pc_stall", 32'(pc_stall), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'd0);
    check("rst_misaligned", 32'(id_misaligned), 32'd0);

    // c0: reset released, PC 0 issued
    rst_n = 1'b1; #1;
    check("c0_valid", 32'(id_valid), 32'd0);
    check("c0_pc_stall", 32'(pc_stall), 32'd0);
    check("c0_addr", 32'(imem_addr), 32'd0);
    next_cycle(); #1;
    check("c1_valid", 32'(id_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); #1;
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_pc", id_pc, 32'(4 * k));
      check("stream_instr", id_instr, 32'h1000_0000 + 32'(k));
    end

    // c6..c10: ID stall with one entry held and one fetch in flight
    next_cycle(); id_stall = 1'b1; #1;
    check("stall_pc_stall", 32'(pc_stall), 32'd1);
    check("stall_pc", id_pc, 32'h10);
    check("stall_instr", id_instr, 32'h1000_0004);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); #1;
      check("stall_hold_pc_stall", 32'(pc_stall), 32'd1);
      check("stall_hold_pc", id_pc, 32'h10);
      check("stall_hold_instr", id_instr, 32'h1000_0004);
    end
    next_cycle(); id_stall = 1'b0; #1;
    check("release_pc_stall", 32'(pc_stall), 32'd0);
    check("release_pc", id_pc, 32'h10);
    for (int k = 5; k < 7; k++) begin
      next_cycle();
      if (k == 6) begin
        id_jump = 1'b1; target = 32'h100;
      end
      #1;
      check("resume_pc", id_pc, 32'(4 * k));
      check("resume_instr", id_instr, 32'h1000_0000 + 32'(k));
    end
    // c13: jump issued while PC_In = 0x20
    check("jump_addr", 32'(imem_addr), 32'h8);
    check("jump_pc_stall", 32'(pc_stall), 32'd0);
    next_cycle(); id_jump = 1'b0; #1;
    check("jump_gap1_valid", 32'(id_valid), 32'd0);
    next_cycle(); #1;
    check("jump_gap2_valid", 32'(id_valid), 32'd0);
    next_cycle(); #1;
    check("jump_target_pc", id_pc, 32'h100);
    check("jump_target_instr", id_instr, 32'h1000_0040);
    check("jump_target_misaligned", 32'(id_misaligned), 32'd0);

    // c17/c18: fill the buffer, then branch while ID is stalled
    next_cycle(); id_stall = 1'b1; #1;
    check("fill_pc", id_pc, 32'h104);
    check("fill_pc_stall", 32'(pc_stall), 32'd1);
    next_cycle(); ex_branch = 1'b1; target = 32'h200; #1;
    check("branch_pc_stall", 32'(pc_stall), 32'd0);
    check("branch_head_pc", id_pc, 32'h104);
    next_cycle(); ex_branch = 1'b0; id_stall = 1'b0; #1;
    check("branch_empty_valid", 32'(id_valid), 32'd0);
    check("branch_empty_instr", id_instr, NOP);
    next_cycle(); #1;
    check("branch_gap_valid", 32'(id_valid), 32'd0);
    next_cycle(); id_stall = 1'b1; #1;
    check("branch_target_pc", id_pc, 32'h200);
    check("branch_target_instr", id_instr, 32'h1000_0080);

    // c22: buffer full (0x200, 0x204), then reset mid-stream
    next_cycle(); #1;
    check("prereset_pc_stall", 32'(pc_stall), 32'd1);
    check("prereset_pc", id_pc, 32'h200);
    rst_n = 1'b0; #1;
    check("midrst_valid", 32'(id_valid), 32'd0);
    check("midrst_pc_stall", 32'(pc_stall), 32'd0);
    next_cycle(); rst_n = 1'b1; id_stall = 1'b0; #1;
    check("postrst_valid", 32'(id_valid), 32'd0);
    check("postrst_pc", id_pc, 32'd0);
    check("postrst_instr", id_instr, NOP);
    check("postrst_addr", 32'(imem_addr), 32'd0);
    next_cycle(); #1;
    check("restart_gap_valid", 32'(id_valid), 32'd0);
    next_cycle(); #1;
    check("restart_pc0", id_pc, 32'd0);
    check("restart_instr0", id_instr, 32'h1000_0000);

    // c26: redirect to a misaligned target
    next_cycle(); id_jump = 1'b1; target = 32'h102; #1;
    check("restart_pc1", id_pc, 32'd4);
    next_cycle(); id_jump = 1'b0; #1;
    check("mis_addr", 32'(imem_addr), 32'h40);
    check("mis_gap_valid", 32'(id_valid), 32'd0);
    next_cycle(); next_cycle(); #1;
    check("mis_pc", id_pc, 32'h102);
    check("mis_flag", 32'(id_misaligned), 32'd1);
    check("mis_instr", id_instr, 32'h1000_0040);
    next_cycle(); #1;
    check("mis_next_pc", id_pc, 32'h106);
    check("mis_next_instr", id_instr, 32'h1000_0041);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
